cdb_arbiter: RTL and testbench

Shares the single common data bus (CDB) between the two result producers: the ALU and the load/store unit. Each producer writes results into a private DEPTH-entry queue. A round-robin arbiter picks one queue head per cycle and drives it onto a registered CDB broadcast, which the reservation station, ROB and LSB consume. Queue-full flags back-pressure the producers; `_alu_full` feeds the reservation station's issue gate.

---
 rtl/cdb_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-producer result queues round-robin arbitrated onto one registered CDB broadcast.
// Optional macro CDB_ARB_STATS_EN compiles in grant/conflict counters on the _stat_* ports.
module cdb_arbiter_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[head_q];
  // A push while full is dropped; clear discards producer inputs of the same cycle.
  assign do_push = en_i && !clear_i && push_i && !full_o;
  assign do_pop  = en_i && !clear_i && pop_i && !empty_o;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) tail_d = tail_q + AW'(1);
      if (do_pop)  head_d = head_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (do_push) mem_q[tail_q] <= dat_i;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _alu_res_ready,
  input  logic [4:0]  _alu_res_rob_id,
  input  logic [31:0] _alu_res_value,
  output logic        _alu_full,
  input  logic        _ls_res_ready,
  input  logic [4:0]  _ls_res_rob_id,
  input  logic [31:0] _ls_res_value,
  output logic        _ls_full,
  output logic        _cdb_ready,
  output logic [4:0]  _cdb_rob_id,
  output logic [31:0] _cdb_value
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0] _stat_alu_grants,
  output logic [31:0] _stat_ls_grants,
  output logic [31:0] _stat_conflicts
`endif
);
  typedef struct packed {
    logic [4:0]  rob_id;
    logic [31:0] value;
  } cdb_ent_t;

  cdb_ent_t alu_head, ls_head, cdb_q, cdb_d;
  logic     alu_empty, ls_empty, grant_alu, grant_ls;
  logic     prio_q, prio_d, cdb_ready_q, cdb_ready_d;

  cdb_arbiter_fifo #(.DEPTH(DEPTH), .W($bits(cdb_ent_t))) u_alu_q (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .en_i    (rdy_in),
    .clear_i (_clear),
    .push_i  (_alu_res_ready),
    .dat_i   ({_alu_res_rob_id, _alu_res_value}),
    .pop_i   (grant_alu),
    .head_o  (alu_head),
    .empty_o (alu_empty),
    .full_o  (_alu_full)
  );

  cdb_arbiter_fifo #(.DEPTH(DEPTH), .W($bits(cdb_ent_t))) u_ls_q (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .en_i    (rdy_in),
    .clear_i (_clear),
    .push_i  (_ls_res_ready),
    .dat_i   ({_ls_res_rob_id, _ls_res_value}),
    .pop_i   (grant_ls),
    .head_o  (ls_head),
    .empty_o (ls_empty),
    .full_o  (_ls_full)
  );

  // prio names the source that wins when both heads are waiting.
  assign grant_alu = !alu_empty && (ls_empty || !prio_q);
  assign grant_ls  = !ls_empty && !grant_alu;

  always_comb begin
    prio_d      = prio_q;
    cdb_ready_d = cdb_ready_q;
    cdb_d       = cdb_q;
    if (_clear) begin
      prio_d      = 1'b0;
      cdb_ready_d = 1'b0;
    end else if (rdy_in) begin
      cdb_ready_d = grant_alu || grant_ls;
      if (grant_alu) begin
        cdb_d  = alu_head;
        prio_d = 1'b1;
      end else if (grant_ls) begin
        cdb_d  = ls_head;
        prio_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      prio_q      <= 1'b0;
      cdb_ready_q <= 1'b0;
      cdb_q       <= '0;
    end else begin
      prio_q      <= prio_d;
      cdb_ready_q <= cdb_ready_d;
      cdb_q       <= cdb_d;
    end
  end

  assign _cdb_ready  = cdb_ready_q;
  assign _cdb_rob_id = cdb_q.rob_id;
  assign _cdb_value  = cdb_q.value;

`ifdef CDB_ARB_STATS_EN
  logic [31:0] stat_alu_q, stat_ls_q, stat_conf_q;

  // Counters survive a flush; only the reset pin zeroes them.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stat_alu_q  <= '0;
      stat_ls_q   <= '0;
      stat_conf_q <= '0;
    end else if (rdy_in) begin
      if (!_clear && grant_alu)  stat_alu_q  <= stat_alu_q + 32'd1;
      if (!_clear && grant_ls)   stat_ls_q   <= stat_ls_q + 32'd1;
      if (!alu_empty && !ls_empty) stat_conf_q <= stat_conf_q + 32'd1;
    end
  end

  assign _stat_alu_grants = stat_alu_q;
  assign _stat_ls_grants  = stat_ls_q;
  assign _stat_conflicts  = stat_conf_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: table-driven contention vectors, hand-written corner sequences,
// and a queue-based scoreboard checking every cycle.
module tb_cdb_arbiter;
  localparam int DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        alu_v = 1'b0, ls_v = 1'b0;
  logic [4:0]  alu_tag = '0, ls_tag = '0;
  logic [31:0] alu_val = '0, ls_val = '0;
  logic        alu_full, ls_full, cdb_ready;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_val;
`ifdef CDB_ARB_STATS_EN
  logic [31:0] st_alu, st_ls, st_conf;
`endif

  cdb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .rdy_in          (rdy_in),
    ._clear          (clear),
    ._alu_res_ready  (alu_v),
    ._alu_res_rob_id (alu_tag),
    ._alu_res_value  (alu_val),
    ._alu_full       (alu_full),
    ._ls_res_ready   (ls_v),
    ._ls_res_rob_id  (ls_tag),
    ._ls_res_value   (ls_val),
    ._ls_full        (ls_full),
    ._cdb_ready      (cdb_ready),
    ._cdb_rob_id     (cdb_tag),
    ._cdb_value      (cdb_val)
`ifdef CDB_ARB_STATS_EN
    ,
    ._stat_alu_grants(st_alu),
    ._stat_ls_grants (st_ls),
    ._stat_conflicts (st_conf)
`endif
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  // Scoreboard: accepted results wait per source until the model's arbiter grants them.
  logic [36:0] aq[$];
  logic [36:0] lq[$];
  logic        m_prio, m_rdy;
  logic [4:0]  m_tag;
  logic [31:0] m_val;
  int          m_ag, m_lg, m_conf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    lq.delete();
    m_prio = 1'b0;
    m_rdy  = 1'b0;
    m_tag  = '0;
    m_val  = '0;
    m_ag   = 0;
    m_lg   = 0;
    m_conf = 0;
  endtask

  task automatic model_edge();
    logic        a_ne, l_ne, a_full, l_full, g_a, g_l;
    logic [36:0] e;
    a_ne = (aq.size() > 0);
    l_ne = (lq.size() > 0);
    if (rdy_in && a_ne && l_ne) m_conf++;
    if (clear) begin
      aq.delete();
      lq.delete();
      m_prio = 1'b0;
      m_rdy  = 1'b0;
    end else if (rdy_in) begin
      a_full = (aq.size() == DEPTH);
      l_full = (lq.size() == DEPTH);
      g_a = a_ne && (!l_ne || m_prio == 1'b0);
      g_l = l_ne && !g_a;
      m_rdy = g_a || g_l;
      if (g_a) begin
        e = aq.pop_front();
        m_prio = 1'b1;
        m_ag++;
      end else if (g_l) begin
        e = lq.pop_front();
        m_prio = 1'b0;
        m_lg++;
      end
      if (g_a || g_l) begin
        m_tag = e[36:32];
        m_val = e[31:0];
      end
      if (alu_v && !a_full) aq.push_back({alu_tag, alu_val});
      if (ls_v && !l_full)  lq.push_back({ls_tag, ls_val});
    end
  endtask

  task automatic check_outputs();
    chk("cdb_ready", {31'd0, cdb_ready}, {31'd0, m_rdy});
    chk("cdb_rob_id", {27'd0, cdb_tag}, {27'd0, m_tag});
    chk("cdb_value", cdb_val, m_val);
    chk("alu_full", {31'd0, alu_full}, (aq.size() == DEPTH) ? 32'd1 : 32'd0);
    chk("ls_full", {31'd0, ls_full}, (lq.size() == DEPTH) ? 32'd1 : 32'd0);
`ifdef CDB_ARB_STATS_EN
    chk("stat_alu", st_alu, m_ag);
    chk("stat_ls", st_ls, m_lg);
    chk("stat_conf", st_conf, m_conf);
`endif
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input logic av, input logic [4:0] at, input logic [31:0] aval,
                     input logic lv, input logic [4:0] lt, input logic [31:0] lval,
                     input logic clr, input logic rdy);
    alu_v = av; alu_tag = at; alu_val = aval;
    ls_v = lv;  ls_tag = lt;  ls_val = lval;
    clear = clr; rdy_in = rdy;
    model_edge();
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic push(input logic av, input logic [4:0] at, input logic lv, input logic [4:0] lt);
    cyc(av, at, 32'hA000_0000 + {27'd0, at}, lv, lt, 32'hB000_0000 + {27'd0, lt}, 1'b0, 1'b1);
  endtask

  task automatic idle();
    push(1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  // Reset asserted between edges must zero the outputs without a clock.
  task automatic do_reset(input string name);
    @(posedge clk_in);
    #3;
    alu_v = 1'b0; ls_v = 1'b0; clear = 1'b0; rdy_in = 1'b1;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    chk({name, "_ready"}, {31'd0, cdb_ready}, 32'd0);
    chk({name, "_tag"}, {27'd0, cdb_tag}, 32'd0);
    chk({name, "_value"}, cdb_val, 32'd0);
    chk({name, "_alu_full"}, {31'd0, alu_full}, 32'd0);
    chk({name, "_ls_full"}, {31'd0, ls_full}, 32'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  typedef struct {
    logic       av;
    logic [4:0] at;
    logic       lv;
    logic [4:0] lt;
    logic       er;
    logic [4:0] et;
  } vec_t;

  vec_t tbl[8];
  int   alu_seen;
  logic seen_dropped;

  initial begin
    tbl[0] = '{1'b1, 5'd1, 1'b1, 5'd9,  1'b0, 5'd0};
    tbl[1] = '{1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 5'd1};
    tbl[2] = '{1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 5'd9};
    tbl[3] = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd2};
    tbl[4] = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd10};
    tbl[5] = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd3};
    tbl[6] = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd11};
    tbl[7] = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd11};

    model_reset();
    #2;
    check_outputs();
    #10;
    rst_n_in = 1'b1;

    // Single result: visible only after the second edge.
    cyc(1'b1, 5'd3, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("single_not_yet", {31'd0, cdb_ready}, 32'd0);
    idle();
    chk("single_ready", {31'd0, cdb_ready}, 32'd1);
    chk("single_tag", {27'd0, cdb_tag}, 32'd3);
    chk("single_value", cdb_val, 32'h0000_1234);
    idle();
    chk("single_pulse_end", {31'd0, cdb_ready}, 32'd0);

    // Contention: strict alternation from a fresh reset.
    do_reset("rst1");
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].av, tbl[i].at, tbl[i].lv, tbl[i].lt);
      chk($sformatf("tbl%0d_ready", i), {31'd0, cdb_ready}, {31'd0, tbl[i].er});
      chk($sformatf("tbl%0d_tag", i), {27'd0, cdb_tag}, {27'd0, tbl[i].et});
    end
`ifdef CDB_ARB_STATS_EN
    chk("contend_stat_alu", st_alu, 32'd3);
    chk("contend_stat_ls", st_ls, 32'd3);
    chk("contend_stat_conf", st_conf, 32'd5);
`endif

    // Back-pressure: both producers push every cycle, ignoring the full flags.
    alu_seen = 0;
    seen_dropped = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i < 8) push(1'b1, 5'(16 + i), 1'b1, 5'(24 + i));
      else       idle();
      if (cdb_ready && cdb_tag >= 5'd16 && cdb_tag <= 5'd23) alu_seen++;
      if (cdb_ready && (cdb_tag == 5'd23 || cdb_tag == 5'd30)) seen_dropped = 1'b1;
      if (i == 5) begin
        chk("ls_full_rise", {31'd0, ls_full}, 32'd1);
        chk("alu_full_before", {31'd0, alu_full}, 32'd0);
      end
      if (i == 6) chk("alu_full_rise", {31'd0, alu_full}, 32'd1);
      if (i == 7) chk("alu_full_after_pop", {31'd0, alu_full}, 32'd0);
    end
    chk("full_alu_broadcasts", alu_seen, 32'd7);
    chk("dropped_not_broadcast", {31'd0, seen_dropped}, 32'd0);

    // Flush with a simultaneous ALU push: nothing survives.
    for (int i = 0; i < 3; i++) push(1'b1, 5'(1 + i), 1'b1, 5'(9 + i));
    cyc(1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    chk("flush_ready", {31'd0, cdb_ready}, 32'd0);
    chk("flush_alu_full", {31'd0, alu_full}, 32'd0);
    chk("flush_ls_full", {31'd0, ls_full}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("flush_quiet%0d", i), {31'd0, cdb_ready}, 32'd0);
    end

    // Stall: rdy_in low freezes everything, including incoming pushes.
    for (int i = 0; i < 3; i++) push(1'b1, 5'(4 + i), 1'b1, 5'(12 + i));
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 5'd20, 32'h2020, 1'b1, 5'd21, 32'h2121, 1'b0, 1'b0);
      chk($sformatf("stall_hold%0d", i), {31'd0, cdb_ready}, 32'd1);
    end
    do_reset("rst2");

    // Randomised traffic with occasional stalls and flushes.
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 1) == 1, 5'($urandom), $urandom,
          $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
          $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 10; i++) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
